// File: rtl/ws2812_rx.sv
// WS2812 single-wire stream decoder: recovers 24-bit GRB words and frame latches
// from the oversampled serial waveform.
//
// state | meaning
// SYNC  | waiting for a full latch gap before trusting the stream
// IDLE  | aligned, waiting for the first high pulse of a frame
// HIGH  | measuring a high pulse
// LOW   | between bits, watching for the next rise or a latch gap
module ws2812_rx #(
    parameter int T1_MIN       = 7,
    parameter int T_HIGH_MIN   = 2,
    parameter int T_HIGH_MAX   = 15,
    parameter int LATCH_CYCLES = 600,
    parameter int NUM_LEDS     = 4,
    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ws_din,
    output logic [23:0]   pix_data,
    output logic [IW-1:0] pix_idx,
    output logic          pix_valid,
    output logic          frame_done,
    output logic          ovf,
    output logic          err
);
    localparam int HW = $clog2(T_HIGH_MAX + 2);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int PW = $clog2(NUM_LEDS + 1);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t        state, state_n;
    logic          s1, s2, s3;
    logic          rise, fall, lat, bit_in;
    logic [HW-1:0] hcnt;
    logic [LW-1:0] lcnt;
    logic [22:0]   shift, shift_n;
    logic [23:0]   shifted;
    logic [4:0]    bitcnt, bitcnt_n;
    logic [PW-1:0] pixcnt, pixcnt_n;
    logic [23:0]   data_n;
    logic [IW-1:0] idx_n;
    logic          ovf_n, valid_n, fd_n, err_n;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign lat     = (lcnt == LW'(LATCH_CYCLES));
    assign bit_in  = (hcnt >= HW'(T1_MIN));
    assign shifted = {shift, bit_in};

    // Counters hold zero on the opposite level, so each one measures the current run only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            s1 <= ws_din;
            s2 <= s1;
            s3 <= s2;
            if (!s2)
                hcnt <= '0;
            else if (hcnt < HW'(T_HIGH_MAX + 1))
                hcnt <= hcnt + HW'(1);
            if (s2)
                lcnt <= '0;
            else if (lcnt < LW'(LATCH_CYCLES))
                lcnt <= lcnt + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            shift      <= '0;
            bitcnt     <= '0;
            pixcnt     <= '0;
            pix_data   <= '0;
            pix_idx    <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bitcnt     <= bitcnt_n;
            pixcnt     <= pixcnt_n;
            pix_data   <= data_n;
            pix_idx    <= idx_n;
            pix_valid  <= valid_n;
            frame_done <= fd_n;
            ovf        <= ovf_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        shift_n  = shift;
        bitcnt_n = bitcnt;
        pixcnt_n = pixcnt;
        data_n   = pix_data;
        idx_n    = pix_idx;
        ovf_n    = ovf;
        valid_n  = 1'b0;
        fd_n     = 1'b0;
        err_n    = 1'b0;
        case (state)
            SYNC: begin
                bitcnt_n = '0;
                pixcnt_n = '0;
                ovf_n    = 1'b0;
                if (lat)
                    state_n = IDLE;
            end
            IDLE: begin
                if (rise)
                    state_n = HIGH;
            end
            HIGH: begin
                if (hcnt > HW'(T_HIGH_MAX)) begin
                    err_n   = 1'b1;
                    state_n = SYNC;
                end else if (fall) begin
                    if (hcnt < HW'(T_HIGH_MIN)) begin
                        err_n   = 1'b1;
                        state_n = SYNC;
                    end else begin
                        shift_n = shifted[22:0];
                        state_n = LOW;
                        if (bitcnt == 5'd23) begin
                            data_n   = shifted;
                            idx_n    = (pixcnt >= PW'(NUM_LEDS - 1)) ? IW'(NUM_LEDS - 1)
                                                                      : pixcnt[IW-1:0];
                            valid_n  = 1'b1;
                            bitcnt_n = '0;
                            if (pixcnt >= PW'(NUM_LEDS))
                                ovf_n = 1'b1;
                            else
                                pixcnt_n = pixcnt + PW'(1);
                        end else begin
                            bitcnt_n = bitcnt + 5'd1;
                        end
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_n = HIGH;
                end else if (lat) begin
                    // A partial word at the latch is a framing error, not a frame.
                    if (bitcnt != 5'd0)
                        err_n = 1'b1;
                    else if (pixcnt != '0)
                        fd_n = 1'b1;
                    bitcnt_n = '0;
                    pixcnt_n = '0;
                    ovf_n    = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = SYNC;
        endcase
    end
endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: scoreboard of expected pixels popped on pix_valid,
// plus strobe counters checked after each scenario.
module tb_ws2812_rx;
    localparam int P = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ws_din = 1'b0;
    logic [23:0] pix_data;
    logic [1:0]  pix_idx;
    logic        pix_valid, frame_done, ovf, err;

    always #(P/2) clk = ~clk;

    ws2812_rx dut (
        .clk(clk), .rst_n(rst_n), .ws_din(ws_din),
        .pix_data(pix_data), .pix_idx(pix_idx), .pix_valid(pix_valid),
        .frame_done(frame_done), .ovf(ovf), .err(err)
    );

    typedef struct packed {
        logic [23:0] data;
        logic [1:0]  idx;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_assert = 0, n_fail = 0;
    int   cnt_pv = 0, cnt_fd = 0, cnt_err = 0, n_unexp = 0;
    int   pv0, fd0, er0;
    time  t_fall = 0, t_pv = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                cnt_pv++;
                t_pv = $time;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("pix_data", {8'b0, pix_data}, {8'b0, e.data});
                    check("pix_idx", {30'b0, pix_idx}, {30'b0, e.idx});
                    check("ovf_at_pix", {31'b0, ovf}, {31'b0, e.ovf});
                end else begin
                    n_unexp++;
                end
            end
            if (frame_done) begin
                cnt_fd++;
                check("fd_err_excl", {31'b0, err}, 32'd0);
            end
            if (err) cnt_err++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        ws_din = 1'b1;
        idle(hi);
        ws_din = 1'b0;
        t_fall = $time;
        idle(lo);
    endtask

    task automatic send_bits(input logic [23:0] d, input int nbits);
        for (int i = 23; i > 23 - nbits; i--)
            if (d[i]) pulse(8, 7);
            else      pulse(4, 11);
    endtask

    task automatic push(input logic [23:0] d, input logic [1:0] idx, input logic ov);
        sb.push_back({d, idx, ov});
    endtask

    task automatic snap();
        pv0 = cnt_pv;
        fd0 = cnt_fd;
        er0 = cnt_err;
    endtask

    task automatic deltas(input string tag, input int dpv, input int dfd, input int der);
        check({tag, "_pv"}, cnt_pv - pv0, dpv);
        check({tag, "_fd"}, cnt_fd - fd0, dfd);
        check({tag, "_err"}, cnt_err - er0, der);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, {8'b0, pix_data}, 32'd0);
        check({tag, "_idx"}, {30'b0, pix_idx}, 32'd0);
        check({tag, "_pv"}, {31'b0, pix_valid}, 32'd0);
        check({tag, "_fd"}, {31'b0, frame_done}, 32'd0);
        check({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    logic [23:0] words2 [4] = '{24'h123456, 24'hABCDEF, 24'h000001, 24'h800000};
    logic [23:0] words3 [5] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};

    initial begin
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(610);

        // single word, latency and frame latch
        snap();
        push(24'h00FF00, 2'd0, 1'b0);
        send_bits(24'h00FF00, 24);
        check("latency_cycles", 32'((t_pv - t_fall) / P), 32'd3);
        idle(620);
        deltas("t1", 1, 1, 0);
        check("t1_ovf", {31'b0, ovf}, 32'd0);

        // four-pixel frame
        snap();
        for (int i = 0; i < 4; i++) begin
            push(words2[i], 2'(i), 1'b0);
            send_bits(words2[i], 24);
        end
        idle(620);
        deltas("t2", 4, 1, 0);

        // overflow on the fifth pixel
        snap();
        for (int i = 0; i < 5; i++) begin
            push(words3[i], (i > 3) ? 2'd3 : 2'(i), (i == 4));
            send_bits(words3[i], 24);
        end
        idle(5);
        check("t3_ovf_sticky", {31'b0, ovf}, 32'd1);
        idle(620);
        deltas("t3", 5, 1, 0);
        check("t3_ovf_cleared", {31'b0, ovf}, 32'd0);

        // 6 cycles high decodes as 0, 7 as 1
        snap();
        push(24'h000FFF, 2'd0, 1'b0);
        repeat (12) pulse(6, 9);
        repeat (12) pulse(7, 8);
        idle(620);
        deltas("t4a", 1, 1, 0);

        // 1-cycle glitch: err, then the stream is ignored until a latch gap
        snap();
        pulse(1, 20);
        check("t4b_err", cnt_err - er0, 1);
        send_bits(24'hA5A5A5, 24);
        idle(620);
        deltas("t4b", 0, 0, 1);

        // 16-cycle high: err, resync, then a fresh word decodes at index 0
        snap();
        pulse(16, 20);
        check("t4c_err", cnt_err - er0, 1);
        send_bits(24'h5A5A5A, 24);
        check("t4c_ignored_pv", cnt_pv - pv0, 0);
        idle(620);
        push(24'h0F0F0F, 2'd0, 1'b0);
        send_bits(24'h0F0F0F, 24);
        idle(620);
        deltas("t4c", 1, 1, 1);

        // partial word at latch
        snap();
        send_bits(24'hABC000, 12);
        idle(620);
        deltas("t5a", 0, 0, 1);
        push(24'hC0FFEE, 2'd0, 1'b0);
        send_bits(24'hC0FFEE, 24);
        idle(620);
        deltas("t5b", 1, 1, 1);

        // reset mid-word, outputs clear without a clock edge
        snap();
        send_bits(24'h3C3000, 10);
        ws_din = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_all_zero("async_rst");
        idle(4);
        ws_din = 1'b0;
        idle(7);
        rst_n = 1'b1;
        send_bits(24'h3C3000, 13);
        send_bits(24'h999999, 24);
        idle(620);
        deltas("t6a", 0, 0, 0);
        push(24'h7E7E7E, 2'd0, 1'b0);
        send_bits(24'h7E7E7E, 24);
        idle(620);
        deltas("t6b", 1, 1, 0);

        check("sb_empty", sb.size(), 0);
        check("unexpected_pv", n_unexp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
